// File: rtl/as_pack.sv
// Shared types and constants for the data-bus decode/response path.
package as_pack;

   localparam int chipsel         = 4;
   localparam int ddata_width     = 64;
   localparam int BUS_TIMEOUT_DEF = 256;

   typedef enum logic [1:0] {
      BS_IDLE,
      BS_WAIT,
      BS_ERR,
      BS_RESP
   } bus_state_t;

   // True when exactly one select line is set.
   function automatic logic is_onehot(input logic [chipsel-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < chipsel; i++) n += int'(v[i]);
      return (n == 1);
   endfunction

endpackage

// File: rtl/as_onehot_mux.sv
// One-hot select of W-wide slices; shared by the data and instruction response paths.
module as_onehot_mux
   import as_pack::*;
#(
   parameter int N = chipsel,
   parameter int W = ddata_width
) (
   input  logic [N-1:0]   sel,
   input  logic [N*W-1:0] din,
   output logic [W-1:0]   dout
);

   // AND-OR structure: a zero select yields zero rather than an arbitrary slice.
   always_comb begin
      dout = '0;
      for (int i = 0; i < N; i++) dout |= din[i*W +: W] & {W{sel[i]}};
   end

endmodule

// File: rtl/as_bus_resp.sv
// Data-bus response side: holds the chip select, waits for the selected slave's ack
// and returns a single-cycle completion; unmapped or silent slaves complete with error.
module as_bus_resp
   import as_pack::*;
#(
   parameter int TIMEOUT_CYCLES = BUS_TIMEOUT_DEF,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           req_i,
   input  logic [chipsel-1:0]             cs_i,
   output logic [chipsel-1:0]             slv_sel_o,
   input  logic [chipsel-1:0]             slv_ack_i,
   input  logic [chipsel*ddata_width-1:0] slv_rdata_i,
   output logic                           busy_o,
   output logic                           ack_o,
   output logic                           err_o,
   output logic [ddata_width-1:0]         rdata_o
);

   localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT_CYCLES - 1);

   bus_state_t             state;
   logic [chipsel-1:0]     sel_q;
   logic [CNT_W-1:0]       timer;
   logic [ddata_width-1:0] rdata_q;
   logic                   err_q;
   logic [ddata_width-1:0] mux_d;
   logic                   hit;

   as_onehot_mux #(.N(chipsel), .W(ddata_width)) u_mux (
      .sel  (sel_q),
      .din  (slv_rdata_i),
      .dout (mux_d)
   );

   // Only the held select can complete the access; foreign acks are masked out.
   assign hit = |(slv_ack_i & sel_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= BS_IDLE;
         sel_q   <= '0;
         timer   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            BS_IDLE: begin
               if (req_i) begin
                  if (is_onehot(cs_i)) begin
                     sel_q <= cs_i;
                     timer <= '0;
                     state <= BS_WAIT;
                  end else begin
                     state <= BS_ERR;
                  end
               end
            end
            BS_WAIT: begin
               // A late ack on the final wait cycle still beats the timeout.
               if (hit) begin
                  rdata_q <= mux_d;
                  err_q   <= 1'b0;
                  state   <= BS_RESP;
               end else if (timer == TMAX) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  state   <= BS_RESP;
               end else begin
                  timer <= timer + CNT_W'(1);
               end
            end
            BS_ERR: begin
               rdata_q <= '0;
               err_q   <= 1'b1;
               state   <= BS_RESP;
            end
            BS_RESP: state <= BS_IDLE;
            default: state <= BS_IDLE;
         endcase
      end
   end

   // All core-facing outputs decode registered state only.
   assign slv_sel_o = (state == BS_WAIT) ? sel_q : '0;
   assign busy_o    = (state != BS_IDLE);
   assign ack_o     = (state == BS_RESP);
   assign err_o     = (state == BS_RESP) & err_q;
   assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_as_bus_resp.sv
// Randomized scoreboard bench for as_bus_resp with a transaction-level timing model.
module tb_as_bus_resp;
   import as_pack::*;

   localparam int T = 8;

   logic                           clk_i = 1'b0;
   logic                           rst_i = 1'b1;
   logic                           req_i = 1'b0;
   logic [chipsel-1:0]             cs_i = '0;
   logic [chipsel-1:0]             slv_sel_o;
   logic [chipsel-1:0]             slv_ack_i = '0;
   logic [chipsel*ddata_width-1:0] slv_rdata_i = '0;
   logic                           busy_o;
   logic                           ack_o;
   logic                           err_o;
   logic [ddata_width-1:0]         rdata_o;

   as_bus_resp #(.TIMEOUT_CYCLES(T)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       (req_i),
      .cs_i        (cs_i),
      .slv_sel_o   (slv_sel_o),
      .slv_ack_i   (slv_ack_i),
      .slv_rdata_i (slv_rdata_i),
      .busy_o      (busy_o),
      .ack_o       (ack_o),
      .err_o       (err_o),
      .rdata_o     (rdata_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      int                     cyc;
      logic                   err;
      logic [ddata_width-1:0] data;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   // Expected transaction schedule, published by the driver for the monitor.
   bit                 txn_act = 1'b0;
   bit                 t_oh = 1'b0;
   int                 t_n = 0;
   int                 t_a = 0;
   int                 t_rst = 0;
   logic [chipsel-1:0] t_cs = '0;
   logic [chipsel-1:0] exp_sel_n = '0;
   logic               exp_busy_n = 1'b0;
   logic [ddata_width-1:0] last_rdata = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, expv);
      end
   endtask

   // Expected busy/select for the cycle after the current one.
   task automatic set_exp();
      int c1;
      bit in_txn;
      c1 = cyc + 1;
      in_txn = txn_act && (c1 >= t_n + 1) && (c1 < t_rst);
      exp_busy_n = in_txn && (c1 <= t_a);
      exp_sel_n  = (in_txn && t_oh && (c1 <= t_a - 1)) ? t_cs : '0;
   endtask

   task automatic rand_data();
      for (int i = 0; i < chipsel; i++)
         slv_rdata_i[i*ddata_width +: ddata_width] = {$urandom, $urandom};
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         req_i = 1'b0;
         slv_ack_i = 4'($urandom);
         rand_data();
         set_exp();
         @(negedge clk_i);
      end
   endtask

   // One access: hit = wait cycle (1..T) where the selected slave acks, else timeout.
   task automatic txn(input logic [3:0] cs, input int hit, input logic [3:0] noise,
                      input bit extra, input bit do_rst, input logic [63:0] d);
      int   n, a, idx, last;
      bit   oh, hv;
      exp_t e;
      n   = cyc;
      oh  = $onehot(cs);
      hv  = oh && (hit >= 1) && (hit <= T);
      idx = 0;
      for (int i = 0; i < chipsel; i++) if (cs[i]) idx = i;
      if (!oh)     a = n + 2;
      else if (hv) a = n + hit + 1;
      else         a = n + T + 1;
      if (do_rst) begin
         last = 3; t_a = 1 << 30; t_rst = n + 4;
      end else begin
         last = a - n - 1; t_a = a; t_rst = 1 << 30;
         e.cyc = a; e.err = !hv; e.data = hv ? d : '0;
         sbq.push_back(e);
      end
      t_n = n; t_oh = oh; t_cs = cs; txn_act = 1'b1;
      req_i = 1'b1; cs_i = cs; slv_ack_i = '0; rand_data();
      set_exp();
      @(negedge clk_i);
      for (int k = 1; k <= last; k++) begin
         req_i = extra && (k == 1);
         cs_i  = extra ? 4'b0010 : 4'($urandom);
         slv_ack_i = noise & ~cs;
         rand_data();
         if (oh && k == hit) begin
            slv_ack_i = slv_ack_i | cs;
            slv_rdata_i[idx*ddata_width +: ddata_width] = d;
         end
         rst_i = do_rst && (k == 3);
         set_exp();
         @(negedge clk_i);
      end
      req_i = 1'b0; rst_i = 1'b0; slv_ack_i = noise; rand_data();
      set_exp();
      @(negedge clk_i);
      txn_act = 1'b0;
   endtask

   // Monitor: per-cycle busy/select checks and scoreboard pop on ack_o.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_i);
         #1;
         if (rst_i) last_rdata = '0;
         chk("busy", 64'(busy_o), 64'(exp_busy_n));
         chk("slv_sel", 64'(slv_sel_o), 64'(exp_sel_n));
         if (ack_o) begin
            if (sbq.size() == 0) begin
               chk("unexpected_ack", 64'(ack_o), 64'd0);
            end else begin
               e = sbq.pop_front();
               chk("ack_cycle", 64'(cyc), 64'(e.cyc));
               chk("err", 64'(err_o), 64'(e.err));
               chk("rdata", rdata_o, e.data);
               last_rdata = e.data;
            end
         end else begin
            chk("err_idle", 64'(err_o), 64'd0);
            chk("rdata_hold", rdata_o, last_rdata);
            if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
               e = sbq.pop_front();
               chk("ack_missing", 64'(ack_o), 64'd1);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] cs;
      rst_i = 1'b1;
      idle(3);
      rst_i = 1'b0;
      idle(2);
      // Memory read, minimum latency.
      txn(4'b0001, 1, 4'b0000, 1'b0, 1'b0, 64'hDEAD_BEEF_0123_4567);
      idle(1);
      // Non-selected slave acks every cycle; selected acks on the 4th wait cycle.
      txn(4'b0100, 4, 4'b0010, 1'b0, 1'b0, 64'h55);
      // Unmapped and multi-hot selects.
      txn(4'b0000, 1, 4'b1111, 1'b0, 1'b0, 64'h1234);
      txn(4'b0110, 1, 4'b1111, 1'b0, 1'b0, 64'h5678);
      // Timeout, then ack on the last wait cycle.
      txn(4'b1000, 0, 4'b0111, 1'b0, 1'b0, 64'h0);
      txn(4'b1000, T, 4'b0111, 1'b0, 1'b0, 64'hCAFE_F00D_0000_0001);
      // Second request while busy is ignored.
      txn(4'b0001, 2, 4'b0000, 1'b1, 1'b0, 64'hA5A5_5A5A_A5A5_5A5A);
      // Reset mid-wait drops the access.
      txn(4'b0010, 0, 4'b0000, 1'b0, 1'b1, 64'h0);
      idle(3);
      for (int r = 0; r < 60; r++) begin
         if ($urandom_range(0, 9) < 7) cs = 4'(1 << $urandom_range(0, 3));
         else                          cs = 4'($urandom);
         txn(cs, $urandom_range(1, T + 2), 4'($urandom), ($urandom_range(0, 3) == 0),
             1'b0, {$urandom, $urandom});
         idle($urandom_range(0, 2));
      end
      idle(4);
      chk("sb_empty", 64'(sbq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
